led_sequencer: RTL and testbench

- Controls the board LEDs on the artyz7 top level and drives the `led` vector.
- Each LED has an independently configured mode: off, on, blink, or chase.
- A valid/ready config port writes the modes; it is fed by a register bank or a test stimulus block.
- A shared prescaler provides the time base, and per-LED counters schedule blinking and the chase token.

---
 rtl/led_sequencer.sv | 165 ++++++++++++++++
 tb/tb_led_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED sequencer: per-LED OFF/ON/BLINK/CHASE modes on a shared tick time base,
// configured one word at a time through a valid/ready port.
module led_sequencer #(
  parameter int num_leds     = 4,
  parameter int tick_divider = 125000,
  parameter int period_width = 8
) (
  input  logic                    ext_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_index,
  input  logic [1:0]              cfg_mode,
  input  logic [period_width-1:0] cfg_period,
  output logic [num_leds-1:0]     led,
  output logic                    tick
);

  localparam int presc_w = $clog2(tick_divider);
  localparam int pos_w   = (num_leds > 1) ? $clog2(num_leds) : 1;
  localparam logic [7:0] num_leds_b = 8'(num_leds);

  localparam logic [1:0] mode_off   = 2'd0;
  localparam logic [1:0] mode_on    = 2'd1;
  localparam logic [1:0] mode_blink = 2'd2;
  localparam logic [1:0] mode_chase = 2'd3;

  typedef enum logic [1:0] {s_init, s_idle, s_apply} state_t;

  state_t                  state, state_next;
  logic                    accept;
  logic                    apply;
  logic                    apply_chase;
  logic [presc_w-1:0]      presc;
  logic [7:0]              lat_index;
  logic [1:0]              lat_mode;
  logic [period_width-1:0] lat_period;
  logic [1:0]              mode   [num_leds];
  logic [period_width-1:0] period [num_leds];
  logic [period_width-1:0] cnt    [num_leds];
  logic [num_leds-1:0]     phase;
  logic [period_width-1:0] chase_period;
  logic [period_width-1:0] chase_cnt;
  logic [pos_w-1:0]        chase_pos;
  logic [num_leds-1:0]     led_next;

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (presc == presc_w'(tick_divider - 1));
      presc <= (presc == presc_w'(tick_divider - 1)) ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state     <= s_init;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_ready <= (state_next == s_idle);
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      s_init:  state_next = s_idle;
      s_idle: begin
        if (cfg_valid && cfg_ready) begin
          accept     = 1'b1;
          state_next = s_apply;
        end
      end
      s_apply: state_next = s_idle;
      default: state_next = s_init;
    endcase
  end

  assign apply       = (state == s_apply);
  assign apply_chase = apply && (lat_mode == mode_chase) && (lat_index < num_leds_b);

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      lat_index  <= '0;
      lat_mode   <= mode_off;
      lat_period <= '0;
    end else if (accept) begin
      lat_index  <= cfg_index;
      lat_mode   <= cfg_mode;
      lat_period <= cfg_period;
    end
  end

  // A config write to an LED overrides any tick landing on the same cycle.
  always_ff @(posedge ext_clk) begin
    if (reset) begin
      for (int i = 0; i < num_leds; i++) begin
        mode[i]   <= mode_off;
        period[i] <= '0;
        cnt[i]    <= '0;
      end
      phase <= '0;
    end else begin
      for (int i = 0; i < num_leds; i++) begin
        if (apply && (lat_index == 8'(i))) begin
          mode[i]   <= lat_mode;
          period[i] <= lat_period;
          cnt[i]    <= '0;
          phase[i]  <= 1'b0;
        end else if (mode[i] == mode_blink) begin
          if (tick) begin
            if (cnt[i] == period[i]) begin
              cnt[i]   <= '0;
              phase[i] <= ~phase[i];
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        end else begin
          cnt[i]   <= '0;
          phase[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      chase_period <= '0;
      chase_cnt    <= '0;
      chase_pos    <= '0;
    end else if (apply_chase) begin
      chase_period <= lat_period;
      chase_cnt    <= '0;
      chase_pos    <= '0;
    end else if (tick) begin
      if (chase_cnt == chase_period) begin
        chase_cnt <= '0;
        chase_pos <= (chase_pos == pos_w'(num_leds - 1)) ? '0 : chase_pos + 1'b1;
      end else begin
        chase_cnt <= chase_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < num_leds; i++) begin
      led_next[i] = enable && ((mode[i] == mode_on) ||
                               ((mode[i] == mode_blink) && phase[i]) ||
                               ((mode[i] == mode_chase) && (chase_pos == pos_w'(i))));
    end
  end

  always_ff @(posedge ext_clk) begin
    if (reset) led <= '0;
    else       led <= led_next;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: tick-counting reference model feeds a queue of expected
// per-cycle outputs; a negedge monitor pops and compares them.
module tb_led_sequencer;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int PW = 8;

  logic          ext_clk = 1'b0;
  logic          reset, enable, cfg_valid, cfg_ready, tick;
  logic [7:0]    cfg_index;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_period;
  logic [N-1:0]  led;

  int checks = 0;
  int fails  = 0;

  led_sequencer #(.num_leds(N), .tick_divider(D), .period_width(PW)) dut (
    .ext_clk(ext_clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_index(cfg_index),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .led(led), .tick(tick)
  );

  always #5 ext_clk = ~ext_clk;

  typedef struct packed {
    logic [N-1:0] led;
    logic         tick;
    logic         ready;
  } exp_t;
  exp_t q[$];

  // Reference model: blink phase and chase position are derived from the number
  // of ticks seen since the relevant config write, by division.
  int     m_mode[N];
  int     m_per[N];
  int     m_n[N];
  int     m_c, m_m, m_cper, m_idx, m_lmode, m_lper;
  bit     m_pend;
  bit     e_tick, e_ready;
  logic [N-1:0] e_led;

  always @(posedge ext_clk) begin : model
    logic [N-1:0] led_new;
    int pos;
    bit tin;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_per[i] = 0; m_n[i] = 0;
      end
      m_c = 0; m_m = 0; m_cper = 0; m_pend = 0;
      m_idx = 0; m_lmode = 0; m_lper = 0;
      e_tick = 0; e_ready = 0; e_led = '0;
    end else begin
      pos = (m_m / (m_cper + 1)) % N;
      for (int i = 0; i < N; i++)
        led_new[i] = enable && ((m_mode[i] == 1) ||
                                (m_mode[i] == 2 && ((m_n[i] / (m_per[i] + 1)) % 2 == 1)) ||
                                (m_mode[i] == 3 && pos == i));
      tin = e_tick;
      m_c++;
      e_tick = (m_c % D == 0);
      for (int i = 0; i < N; i++) begin
        if (m_pend && m_idx == i) begin
          m_mode[i] = m_lmode; m_per[i] = m_lper; m_n[i] = 0;
        end else begin
          m_n[i] += int'(tin);
        end
      end
      if (m_pend && m_idx < N && m_lmode == 3) begin
        m_cper = m_lper; m_m = 0;
      end else begin
        m_m += int'(tin);
      end
      if (m_pend) m_pend = 0;
      else if (e_ready && cfg_valid) begin
        m_pend = 1;
        m_idx = int'(cfg_index); m_lmode = int'(cfg_mode); m_lper = int'(cfg_period);
      end
      e_ready = !m_pend;
      e_led = led_new;
    end
    q.push_back('{led: e_led, tick: e_tick, ready: e_ready});
  end

  always @(negedge ext_clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 3;
      if (led !== e.led) begin
        fails++;
        $display("FAIL led t=%0t got=%b want=%b", $time, led, e.led);
      end
      if (tick !== e.tick) begin
        fails++;
        $display("FAIL tick t=%0t got=%b want=%b", $time, tick, e.tick);
      end
      if (cfg_ready !== e.ready) begin
        fails++;
        $display("FAIL cfg_ready t=%0t got=%b want=%b", $time, cfg_ready, e.ready);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge ext_clk);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input int idx, input int mode, input int per, input bit keep);
    int k = 0;
    cfg_valid  = 1'b1;
    cfg_index  = 8'(idx);
    cfg_mode   = 2'(mode);
    cfg_period = PW'(per);
    while (!cfg_ready && k < 10) begin
      @(negedge ext_clk);
      k++;
    end
    checks++;
    if (!cfg_ready) begin
      fails++;
      $display("FAIL handshake_timeout t=%0t got=cfg_ready_low want=cfg_ready_high", $time);
    end
    @(negedge ext_clk);
    if (!keep) cfg_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!tick && k < 20) begin
      @(negedge ext_clk);
      k++;
    end
    checks++;
    if (!tick) begin
      fails++;
      $display("FAIL tick_timeout t=%0t got=no_tick want=tick", $time);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_index = '0; cfg_mode = '0; cfg_period = '0;
    repeat (3) @(negedge ext_clk);
    reset  = 1'b0;
    enable = 1'b1;
    wait_cycles(12);

    send(1, 1, 0, 0);
    wait_cycles(3);
    enable = 1'b0;
    wait_cycles(2);
    enable = 1'b1;

    send(0, 2, 2, 0);
    wait_cycles(40);
    send(0, 2, 0, 0);
    wait_cycles(12);

    for (int i = 0; i < N; i++) send(i, 3, 0, 0);
    wait_cycles(24);
    send(2, 0, 0, 0);
    wait_cycles(24);

    send(3, 1, 0, 1);
    send(7, 1, 5, 1);
    send(0, 0, 0, 0);
    wait_cycles(6);

    send(1, 2, 1, 0);
    wait_cycles(5);
    wait_tick();
    repeat (3) @(negedge ext_clk);
    send(1, 2, 1, 0);
    wait_cycles(20);

    send(3, 2, 255, 0);
    wait_cycles(2100);

    repeat (250) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)
        send($urandom_range(0, 5), $urandom_range(0, 3),
             ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      else if (r < 8)
        enable = 1'($urandom_range(0, 1));
      wait_cycles($urandom_range(0, 8));
    end
    cfg_valid = 1'b0;
    enable    = 1'b1;
    wait_cycles(10);

    send(2, 1, 0, 0);
    reset     = 1'b1;
    cfg_valid = 1'b1;
    cfg_index = 8'd1;
    cfg_mode  = 2'd1;
    wait_cycles(3);
    reset     = 1'b0;
    cfg_valid = 1'b0;
    wait_cycles(20);

    wait_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1);
  end

endmodule
